// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory: geometry, default latency, FSM
// state encoding and the request decode used at capture time.
package data_memory_pkg;

  localparam int DMEM_DEPTH         = 256;
  localparam int DMEM_AW            = 8;
  localparam int DMEM_DW            = 8;
  localparam int DMEM_ACCESS_CYCLES = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } dmem_op_t;

  // Read wins when both request lines are high, so a conflicting request
  // can never corrupt the array.
  function automatic dmem_op_t decode_op(input logic rd, input logic wr);
    return (wr && !rd) ? OP_WRITE : OP_READ;
  endfunction

  function automatic logic is_conflict(input logic rd, input logic wr);
    return rd && wr;
  endfunction

endpackage

// File: rtl/data_memory_access_timer.sv
// Down-counter that measures one memory access. Loaded on the capture edge,
// it raises expire for exactly the last busy cycle of the access.
module access_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] cycles,
  output logic       expire
);

  logic [3:0] count;

  // The capture cycle is already one of the busy cycles, so the counter
  // only has to cover the remaining cycles-1 of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= cycles - 4'd1;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign expire = (count == 4'd1);

endmodule

// File: rtl/data_memory.sv
// Byte-wide data memory seen by the cpu: one access in flight at a time,
// fixed latency reported through BUSYWAIT, registered READDATA.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ACCESS_CYCLES = DMEM_ACCESS_CYCLES,
  parameter int DEPTH         = DMEM_DEPTH
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [DMEM_AW-1:0] ADDRESS,
  input  logic [DMEM_DW-1:0] WRITEDATA,
  output logic [DMEM_DW-1:0] READDATA,
  output logic               BUSYWAIT,
  output logic               PROTO_ERR,
  output dmem_state_t        dbg_state
);

  // Handshake: a request is the level READ|WRITE seen in IDLE; BUSYWAIT acts
  // as not-ready and is raised in that same cycle. The request is taken at
  // the edge closing that cycle; the cycle after BUSYWAIT falls (DONE) is
  // the ack, READDATA is valid there and the request lines are ignored.
  localparam logic [3:0] ACCESS_CYCLES_4 = 4'(ACCESS_CYCLES);

  dmem_state_t        state;
  dmem_state_t        next_state;
  logic               req;
  logic               capture;
  logic               complete;
  logic               expire;
  logic               busy_c;
  dmem_op_t           lat_op;
  logic [DMEM_AW-1:0] lat_addr;
  logic [DMEM_DW-1:0] lat_data;
  logic [DMEM_DW-1:0] mem [DEPTH];

  assign req      = READ | WRITE;
  assign capture  = (state == IDLE) && req;
  assign complete = (state == BUSY) && expire;

  access_timer u_timer (
    .clk    (CLK),
    .rst    (RESET),
    .load   (capture),
    .cycles (ACCESS_CYCLES_4),
    .expire (expire)
  );

  always_comb begin
    next_state = state;
    busy_c     = 1'b0;
    case (state)
      IDLE: begin
        busy_c = req;
        if (req) next_state = BUSY;
      end
      BUSY: begin
        busy_c = 1'b1;
        if (expire) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The request decode is combinational from the cpu, so RESET must mask it.
  assign BUSYWAIT  = busy_c & ~RESET;
  assign dbg_state = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      READDATA  <= '0;
      PROTO_ERR <= 1'b0;
      lat_op    <= OP_READ;
      lat_addr  <= '0;
      lat_data  <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        lat_op   <= decode_op(READ, WRITE);
        lat_addr <= ADDRESS;
        lat_data <= WRITEDATA;
        if (is_conflict(READ, WRITE)) PROTO_ERR <= 1'b1;
      end
      if (complete && lat_op == OP_READ) begin
        READDATA <= mem[lat_addr];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (complete && lat_op == OP_WRITE) begin
      mem[lat_addr] <= lat_data;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus a randomized
// run, all compared against a behavioural byte-array model.
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int AC = 5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        PROTO_ERR;
  dmem_state_t dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem_model [256];
  logic [7:0] rd_model;
  logic       proto_model;
  logic [7:0] exp_q [$];

  data_memory #(.ACCESS_CYCLES(AC), .DEPTH(256)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT),
    .PROTO_ERR (PROTO_ERR),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    rd_model    = 8'h00;
    proto_model = 1'b0;
  endtask

  task automatic model_access(input logic r, input logic w, input logic [7:0] a,
                              input logic [7:0] d);
    if (r) begin
      rd_model = mem_model[a];
      if (w) proto_model = 1'b1;
    end else if (w) begin
      mem_model[a] = d;
    end
  endtask

  // mode 0: steady inputs, 1: churn ADDRESS/WRITEDATA in cycle T+2,
  // 2: drop the request in cycle T+1.
  task automatic do_access(input logic r, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input int mode, input string tag);
    int         busy_n;
    logic [7:0] exp_rd;
    @(posedge CLK); #1;
    READ = r; WRITE = w; ADDRESS = a; WRITEDATA = d;
    model_access(r, w, a, d);
    exp_q.push_back(rd_model);
    busy_n = 0;
    for (int i = 0; i < AC; i++) begin
      @(negedge CLK);
      if (BUSYWAIT === 1'b1) busy_n++;
      if (mode == 1 && i == 2) begin ADDRESS = a + 8'd1; WRITEDATA = ~d; end
      if (mode == 2 && i == 1) begin READ = 1'b0; WRITE = 1'b0; end
    end
    n_checks++;
    if (busy_n !== AC) $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_n, AC);
    else n_pass++;
    @(negedge CLK);
    exp_rd = exp_q.pop_front();
    n_checks++;
    if (BUSYWAIT !== 1'b0) $display("FAIL %s done_busywait: got %b expected 0", tag, BUSYWAIT);
    else n_pass++;
    n_checks++;
    if (dbg_state !== DONE) $display("FAIL %s done_state: got %0d expected %0d", tag, dbg_state, DONE);
    else n_pass++;
    n_checks++;
    if (READDATA !== exp_rd) $display("FAIL %s readdata: got %h expected %h", tag, READDATA, exp_rd);
    else n_pass++;
    n_checks++;
    if (PROTO_ERR !== proto_model) $display("FAIL %s proto_err: got %b expected %b", tag, PROTO_ERR, proto_model);
    else n_pass++;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    model_reset();
    repeat (2) @(negedge CLK);
    n_checks++;
    if (BUSYWAIT !== 1'b0) $display("FAIL reset_busywait: got %b expected 0", BUSYWAIT);
    else n_pass++;
    n_checks++;
    if (READDATA !== 8'h00) $display("FAIL reset_readdata: got %h expected 00", READDATA);
    else n_pass++;
    n_checks++;
    if (PROTO_ERR !== 1'b0) $display("FAIL reset_proto_err: got %b expected 0", PROTO_ERR);
    else n_pass++;
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    else n_pass++;
    READ = 1'b0;
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic test_write_read();
    do_access(1'b0, 1'b1, 8'h10, 8'hA5, 0, "wr_10");
    do_access(1'b1, 1'b0, 8'h10, 8'h00, 0, "rd_10");
  endtask

  task automatic test_back_to_back();
    int         err;
    logic       exp_bw;
    do_access(1'b0, 1'b1, 8'h11, 8'h3C, 0, "wr_11");
    @(posedge CLK); #1;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h10;
    err = 0;
    for (int i = 0; i < 2 * (AC + 1); i++) begin
      @(negedge CLK);
      exp_bw = ((i % (AC + 1)) != AC);
      if (BUSYWAIT !== exp_bw) err++;
      if (i == AC) begin
        n_checks++;
        if (READDATA !== mem_model[8'h10]) $display("FAIL b2b_first_read: got %h expected %h", READDATA, mem_model[8'h10]);
        else n_pass++;
        ADDRESS = 8'h11;
      end
    end
    n_checks++;
    if (err !== 0) $display("FAIL b2b_busy_pattern: got %0d wrong cycles expected 0", err);
    else n_pass++;
    rd_model = mem_model[8'h11];
    n_checks++;
    if (READDATA !== rd_model) $display("FAIL b2b_second_read: got %h expected %h", READDATA, rd_model);
    else n_pass++;
    READ = 1'b0;
  endtask

  task automatic test_boundary();
    do_access(1'b0, 1'b1, 8'hFF, 8'hFF, 0, "wr_ff");
    do_access(1'b0, 1'b1, 8'h00, 8'h01, 0, "wr_00");
    do_access(1'b1, 1'b0, 8'hFF, 8'h00, 0, "rd_ff");
    do_access(1'b1, 1'b0, 8'h00, 8'h00, 0, "rd_00");
  endtask

  task automatic test_busy_churn();
    do_access(1'b0, 1'b1, 8'h20, 8'h55, 1, "churn_wr_20");
    do_access(1'b1, 1'b0, 8'h21, 8'h00, 0, "churn_rd_21");
    do_access(1'b0, 1'b1, 8'h22, 8'h99, 2, "drop_wr_22");
    do_access(1'b1, 1'b0, 8'h22, 8'h00, 2, "drop_rd_22");
    do_access(1'b1, 1'b0, 8'h20, 8'h00, 0, "churn_rd_20");
  endtask

  task automatic test_reset_mid_access();
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h30; WRITEDATA = 8'h77;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    #1;
    n_checks++;
    if (BUSYWAIT !== 1'b0) $display("FAIL midrst_busywait: got %b expected 0", BUSYWAIT);
    else n_pass++;
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL midrst_state: got %0d expected %0d", dbg_state, IDLE);
    else n_pass++;
    n_checks++;
    if (READDATA !== 8'h00) $display("FAIL midrst_readdata: got %h expected 00", READDATA);
    else n_pass++;
    WRITE = 1'b0;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
    do_access(1'b1, 1'b0, 8'h30, 8'h00, 0, "midrst_rd_30");
  endtask

  task automatic test_proto_err();
    do_access(1'b0, 1'b1, 8'h10, 8'hA5, 0, "perr_wr_10");
    do_access(1'b1, 1'b1, 8'h10, 8'h5A, 0, "perr_both_10");
    repeat (10) @(negedge CLK);
    n_checks++;
    if (PROTO_ERR !== 1'b1) $display("FAIL perr_sticky: got %b expected 1", PROTO_ERR);
    else n_pass++;
    do_access(1'b1, 1'b0, 8'h10, 8'h00, 0, "perr_rd_10");
    pulse_reset();
    n_checks++;
    if (PROTO_ERR !== 1'b0) $display("FAIL perr_after_reset: got %b expected 0", PROTO_ERR);
    else n_pass++;
  endtask

  task automatic test_random();
    int         kind;
    logic       r;
    logic       w;
    logic [7:0] a;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      r = (kind >= 5);
      w = (kind <= 4) || (kind == 9);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 15));
      do_access(r, w, a, 8'($urandom_range(0, 255)), $urandom_range(0, 2), "rand");
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_boundary();
    test_busy_churn();
    test_reset_mid_access();
    test_proto_err();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
